mem_wb_slice: RTL and testbench
===============================

Name: mem_wb_slice

Overview:
- MEM stage plus MEM/WB pipeline register of the 5-stage 16-bit CPU.
- Consumes the EX/MEM bundle (ALU result, store data, M and WB control fields).
- Runs a variable-latency req/ack data-memory handshake and stalls the upstream pipeline while a memory access is outstanding.
- Produces the register-file write port (write_addr, write_data, reg_write) that feeds the decode stage, plus the return-target redirect for RET.

Parameters:
- DATA_W, 16, datapath and memory word width.
- REG_AW, 4, register address width.
- TIMEOUT, 15, max WAIT cycles before abort; used only with MEM_TIMEOUT_EN.
- CNT_W, 4, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM bundle holds a live instruction
- alu_result  in  DATA_W  ALU output; memory address for LW/SW/CALL/RET
- store_data  in  DATA_W  SW/CALL write data
- M  in  2  {MemWrite, MemRead}
- WB  in  7  {dst_addr[3:0], RegWrite, Ret, MemToReg}
- stall  out  1  freeze upstream stages and hold inputs stable
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1=write, 0=read; valid while mem_req
- mem_addr  out  DATA_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- write_addr  out  REG_AW  register-file destination
- write_data  out  DATA_W  register-file data
- reg_write  out  1  register-file write enable
- ret_valid  out  1  one-cycle PC redirect for RET
- ret_target  out  DATA_W  PC value loaded by RET
- mem_err  out  1  timeout abort pulse (0 unless MEM_TIMEOUT_EN)

Behaviour:
- Reset: state IDLE; mem_req, mem_we, mem_addr, mem_wdata, write_addr, write_data, reg_write, ret_valid, mem_err all 0. Reset mid-transaction drops mem_req at the next edge and abandons the access. A late mem_ack after that is ignored.
- memop = in_valid & (M[1] | M[0]).
- FSM states: IDLE, WAIT.
- IDLE, memop=0: no stall. At the edge the WB register loads write_addr=WB[6:3], write_data=alu_result, reg_write=in_valid&WB[2], ret_valid=0. Latency is 1 cycle.
- IDLE, memop=1: stall=1 combinationally. At the edge latch mem_addr=alu_result, mem_wdata=store_data, mem_we=M[1]; set mem_req=1; go to WAIT. The WB register loads a bubble (reg_write=0, ret_valid=0).
- WAIT: mem_req=1. Address, data and we stay constant. stall = ~mem_ack.
- WAIT with mem_ack:
  - At the edge: mem_req=0, go to IDLE.
  - WB loads write_addr=WB[6:3], write_data = WB[0] ? mem_rdata : alu_result, reg_write=WB[2].
  - ret_valid=WB[1]; ret_target=mem_rdata when WB[1], else it holds.
  - The upstream advances on the same edge.
- Minimum memory-op latency is 2 cycles (ack in the first WAIT cycle).
- mem_ack while in IDLE is ignored.
- ret_valid and mem_err are single-cycle pulses. reg_write follows the WB register and is 0 on bubble cycles.
- Writes to any register index are passed through unfiltered.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A CNT_W counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT: mem_req=0, go to IDLE, mem_err=1 for one cycle, WB loads a bubble (reg_write=0, ret_valid=0), stall releases that cycle.
  - An ack arriving in the same cycle as the timeout wins.
- MEM_TIMEOUT_EN undefined: WAIT never times out, mem_err is tied 0, and the counter is not built.

Decomposition:
- cpu_pkg holds:
  - mem_state_t enum {IDLE, WAIT};
  - field index constants M_MEMWRITE=1, M_MEMREAD=0, WB_DST_MSB=6, WB_DST_LSB=3, WB_REGWRITE=2, WB_RET=1, WB_MEMTOREG=0.
- One sub-module, mem_hs_fsm: state register, mem_req/mem_we/mem_addr/mem_wdata latches, timeout counter, stall generation.
- The WB register and write-data mux stay in the top level.

Test Plan:
- ADD with in_valid=1, M=00, WB={4'h3,1,0,0}, alu_result=16'h1234 -> stall=0; next cycle write_addr=3, write_data=1234, reg_write=1.
- LW, M=01, WB={4'h5,1,0,1}, alu_result=16'h0040, ack in 3rd WAIT cycle with rdata=16'hBEEF:
  - mem_req/addr 0040 for 3 cycles;
  - stall high 3 cycles, low in the ack cycle;
  - next cycle write_addr=5, write_data=BEEF.
- SW, M=10, store_data=16'h00AA, ack in 1st WAIT cycle -> mem_we=1, mem_wdata=00AA, 2-cycle op, reg_write stays 0.
- RET, M=01, WB={4'hF,1,1,0}, rdata=16'h0123:
  - ret_valid pulses 1 cycle with ret_target=0123;
  - write_addr=F, write_data=alu_result.
- rst asserted in 2nd WAIT cycle, then mem_ack pulses -> mem_req=0 after the edge, no reg_write, no ret_valid.
- With MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> mem_err pulse after 4 WAIT cycles, stall drops, reg_write=0; a following ADD completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and bundle field positions for the 16-bit CPU pipeline.
package cpu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // M = {MemWrite, MemRead}
    localparam int M_MEMWRITE  = 1;
    localparam int M_MEMREAD   = 0;

    // WB = {dst_addr[3:0], RegWrite, Ret, MemToReg}
    localparam int WB_DST_MSB  = 6;
    localparam int WB_DST_LSB  = 3;
    localparam int WB_REGWRITE = 2;
    localparam int WB_RET      = 1;
    localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/mem_hs_fsm.sv
// Data-memory req/ack handshake: request latches, IDLE/WAIT state and upstream stall.
// Optional MEM_TIMEOUT_EN aborts a WAIT that sees no ack within TIMEOUT cycles.
module mem_hs_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memop_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              mem_ack_i,
    output logic              idle_o,
    output logic              done_o,
`ifdef MEM_TIMEOUT_EN
    output logic              abort_o,
`endif
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o
);

    mem_state_t        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              timeout;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Fires on the last permitted WAIT cycle; a same-cycle ack takes priority.
    assign timeout = (state_q == WAIT) && !mem_ack_i && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign abort_o = timeout;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!mem_ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (memop_i) begin
                    stall_o = 1'b1;
                    state_d = WAIT;
                    req_d   = 1'b1;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                end
            end
            WAIT: begin
                stall_o = ~mem_ack_i & ~timeout;
                if (mem_ack_i) begin
                    done_o  = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idle_o      = (state_q == IDLE);
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/mem_wb_slice.sv
// MEM stage plus MEM/WB register: drives the register-file write port and RET redirect.
// Define MEM_TIMEOUT_EN to abort stuck memory accesses and report them on mem_err.
module mem_wb_slice
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [1:0]        M,
    input  logic [6:0]        WB,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [REG_AW-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              reg_write,
    output logic              ret_valid,
    output logic [DATA_W-1:0] ret_target,
    output logic              mem_err
);

    logic memop;
    logic idle;
    logic done;

    assign memop = in_valid & (M[M_MEMWRITE] | M[M_MEMREAD]);

`ifdef MEM_TIMEOUT_EN
    logic abort;
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
        end
    end

    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    mem_hs_fsm #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_hs (
        .clk         (clk),
        .rst         (rst),
        .memop_i     (memop),
        .we_i        (M[M_MEMWRITE]),
        .addr_i      (alu_result),
        .wdata_i     (store_data),
        .mem_ack_i   (mem_ack),
        .idle_o      (idle),
        .done_o      (done),
`ifdef MEM_TIMEOUT_EN
        .abort_o     (abort),
`endif
        .stall_o     (stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata)
    );

    logic [REG_AW-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              reg_write_q, reg_write_d;
    logic              ret_valid_q, ret_valid_d;
    logic [DATA_W-1:0] ret_target_q, ret_target_d;

    // Every cycle that neither passes an ALU op nor completes an access loads a bubble.
    always_comb begin
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        ret_valid_d  = 1'b0;
        ret_target_d = ret_target_q;
        if (idle && !memop) begin
            write_addr_d = REG_AW'(WB[WB_DST_MSB:WB_DST_LSB]);
            write_data_d = alu_result;
            reg_write_d  = in_valid & WB[WB_REGWRITE];
        end else if (done) begin
            write_addr_d = REG_AW'(WB[WB_DST_MSB:WB_DST_LSB]);
            write_data_d = WB[WB_MEMTOREG] ? mem_rdata : alu_result;
            reg_write_d  = WB[WB_REGWRITE];
            ret_valid_d  = WB[WB_RET];
            if (WB[WB_RET]) begin
                ret_target_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_addr_q <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
            ret_valid_q  <= 1'b0;
            ret_target_q <= '0;
        end else begin
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
            ret_valid_q  <= ret_valid_d;
            ret_target_q <= ret_target_d;
        end
    end

    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign reg_write  = reg_write_q;
    assign ret_valid  = ret_valid_q;
    assign ret_target = ret_target_q;

endmodule

// File: tb/tb_mem_wb_slice.sv
// Scoreboard bench for mem_wb_slice: driver pushes expected write-back events, monitor pops and compares.
module tb_mem_wb_slice;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 15;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic [1:0]  M;
    logic [6:0]  WB;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [3:0]  write_addr;
    logic [15:0] write_data;
    logic        reg_write;
    logic        ret_valid;
    logic [15:0] ret_target;
    logic        mem_err;

    mem_wb_slice #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .alu_result (alu_result),
        .store_data (store_data),
        .M          (M),
        .WB         (WB),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .write_addr (write_addr),
        .write_data (write_data),
        .reg_write  (reg_write),
        .ret_valid  (ret_valid),
        .ret_target (ret_target),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        rw;
        logic        rv;
        logic        err;
        logic [15:0] tgt;
        logic        tk;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] m_tgt    = 16'h0;
    logic        m_tgt_known = 1'b0;
    logic [15:0] mem_model [logic [15:0]];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each scheduled write-back event must appear exactly on its cycle, nothing else may.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("wb_reg_write", reg_write, e.rw);
            chk("wb_ret_valid", ret_valid, e.rv);
            chk("wb_mem_err", mem_err, e.err);
            if (e.rw) begin
                chk("wb_write_addr", write_addr, e.wa);
                chk("wb_write_data", write_data, e.wd);
            end
            if (e.tk) chk("wb_ret_target", ret_target, e.tgt);
        end else if (reg_write === 1'b1 || ret_valid === 1'b1 || mem_err === 1'b1) begin
            chk("wb_unexpected", {reg_write, ret_valid, mem_err}, 3'b000);
        end
    end

    task automatic issue(input logic v, input logic [1:0] m, input logic [6:0] wb,
                         input logic [15:0] alu, input logic [15:0] sd,
                         input int lat, input logic [15:0] rd);
        logic memop;
        exp_t e;
        memop      = v & (m[1] | m[0]);
        in_valid   = v;
        M          = m;
        WB         = wb;
        alu_result = alu;
        store_data = sd;
        if (!memop) begin
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
            @(negedge clk);
            chk("stall_alu", stall, 1'b0);
            chk("req_alu", mem_req, 1'b0);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            e.rw  = v & wb[2];
            e.wd  = alu;
            e.rv  = 1'b0;
        end else begin
            mem_ack = 1'b0;
            @(negedge clk);
            chk("stall_issue", stall, 1'b1);
            chk("req_issue", mem_req, 1'b0);
            @(posedge clk); #1;
            for (int i = 1; i <= lat; i++) begin
                mem_ack   = (i == lat);
                mem_rdata = (i == lat) ? rd : 16'($urandom);
                @(negedge clk);
                chk("wait_req", mem_req, 1'b1);
                chk("wait_addr", mem_addr, alu);
                chk("wait_we", mem_we, m[1]);
                chk("wait_wdata", mem_wdata, sd);
                chk("wait_stall", stall, (i != lat));
                @(posedge clk); #1;
            end
            mem_ack = 1'b0;
            e.rw  = wb[2];
            e.wd  = wb[0] ? rd : alu;
            e.rv  = wb[1];
            if (wb[1]) begin
                m_tgt       = rd;
                m_tgt_known = 1'b1;
            end
        end
        e.err = 1'b0;
        e.wa  = wb[6:3];
        e.tgt = m_tgt;
        e.tk  = m_tgt_known;
        e.due = cyc;
        if (e.rw || e.rv) exp_q.push_back(e);
        in_valid = 1'b0;
    endtask

    // Reset lands in the second WAIT cycle, then a stale ack arrives.
    task automatic reset_mid();
        in_valid   = 1'b1;
        M          = 2'b01;
        WB         = 7'b0111_111;
        alu_result = 16'h0010;
        mem_ack    = 1'b0;
        @(negedge clk);
        chk("rst_issue_stall", stall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_wait1_req", mem_req, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait2_req", mem_req, 1'b1);
        @(posedge clk); #1;
        rst         = 1'b0;
        in_valid    = 1'b0;
        M           = 2'b00;
        mem_ack     = 1'b1;
        mem_rdata   = 16'hDEAD;
        m_tgt_known = 1'b0;
        @(negedge clk);
        chk("rst_req_dropped", mem_req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_reg_write", reg_write, 1'b0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_reg_write", reg_write, 1'b0);
        chk("late_ack_ret_valid", ret_valid, 1'b0);
        chk("late_ack_req", mem_req, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic        v;
        logic [1:0]  m;
        logic [6:0]  wb;
        logic [15:0] alu, sd, rd;
        int          lat;
        exp_t        te;

        rst = 1'b1; in_valid = 1'b0; M = 2'b00; WB = 7'h0;
        alu_result = 16'h0; store_data = 16'h0; mem_rdata = 16'h0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_mem_we", mem_we, 1'b0);
        chk("reset_mem_addr", mem_addr, 16'h0);
        chk("reset_mem_wdata", mem_wdata, 16'h0);
        chk("reset_write_addr", write_addr, 4'h0);
        chk("reset_write_data", write_data, 16'h0);
        chk("reset_reg_write", reg_write, 1'b0);
        chk("reset_ret_valid", ret_valid, 1'b0);
        chk("reset_mem_err", mem_err, 1'b0);
        chk("reset_stall", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(1'b1, 2'b00, 7'b0011_100, 16'h1234, 16'h0000, 0, 16'h0);   // ADD r3
        issue(1'b1, 2'b01, 7'b0101_101, 16'h0040, 16'h0000, 3, 16'hBEEF); // LW r5
        issue(1'b1, 2'b10, 7'b0000_000, 16'h0050, 16'h00AA, 1, 16'h7777); // SW
        issue(1'b1, 2'b01, 7'b1111_110, 16'h0060, 16'h0000, 2, 16'h0123); // RET
        issue(1'b0, 2'b01, 7'b0010_100, 16'h0070, 16'h0000, 0, 16'h0);    // memop bits but not valid
        reset_mid();

`ifdef MEM_TIMEOUT_EN
        in_valid = 1'b1; M = 2'b01; WB = 7'b0101_111; alu_result = 16'h0008; mem_ack = 1'b0;
        @(negedge clk);
        chk("to_issue_stall", stall, 1'b1);
        @(posedge clk); #1;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            chk("to_wait_req", mem_req, 1'b1);
            chk("to_wait_stall", stall, (i != TO));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        te.due = cyc; te.wa = 4'h0; te.wd = 16'h0; te.rw = 1'b0; te.rv = 1'b0;
        te.err = 1'b1; te.tgt = m_tgt; te.tk = m_tgt_known;
        exp_q.push_back(te);
        issue(1'b1, 2'b00, 7'b1001_100, 16'h4321, 16'h0000, 0, 16'h0);
`endif

        for (int n = 0; n < 150; n++) begin
            v   = ($urandom_range(0, 7) != 0);
            m   = 2'($urandom_range(0, 3));
            wb  = 7'($urandom);
            sd  = 16'($urandom);
            lat = $urandom_range(1, 4);
            rd  = 16'h0;
            if (v && m != 2'b00) begin
                alu = 16'($urandom_range(0, 15));
                if (m[1]) begin
                    rd = 16'($urandom);
                    mem_model[alu] = sd;
                end else begin
                    if (!mem_model.exists(alu)) mem_model[alu] = 16'($urandom);
                    rd = mem_model[alu];
                end
            end else begin
                alu = 16'($urandom);
            end
            issue(v, m, wb, alu, sd, lat, rd);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
